// File: rtl/disp_scan_decoder.sv
// Recovers the four digit values from a multiplexed, active-low anode scan.
// A digit is captured only after its anode and value stay stable for SETTLE
// cycles. Once all four digits are seen, the frame is committed to dig0..dig3
// and handed to the consumer with a valid/ack handshake.
module disp_scan_decoder #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       an0,
    input  logic       an1,
    input  logic       an2,
    input  logic       an3,
    input  logic [3:0] char,
    input  logic       frame_ack,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic       frame_valid,
    output logic       overrun,
    output logic       multi_err
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_HOLD
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [3:0] an_r;
    logic [3:0] char_r;

    logic       is_one;
    logic       is_multi;
    logic [1:0] one_idx;

    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic [3:0] cnt_inc;
    logic [1:0] digit;
    logic [1:0] digit_next;
    logic [3:0] held;
    logic [3:0] held_next;
    logic       cap;

    logic [3:0] seen;
    logic [3:0] seen_set;
    logic       commit;
    logic [3:0] shadow [4];

    // Register the raw scan inputs once so every decision uses a clean sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_r   <= 4'hF;
            char_r <= 4'h0;
        end else begin
            an_r   <= {an3, an2, an1, an0};
            char_r <= char;
        end
    end

    // Classify the sampled anode pattern as none, exactly one lit, or several lit.
    always_comb begin
        is_one   = 1'b0;
        is_multi = 1'b0;
        one_idx  = 2'd0;
        case (an_r)
            4'b1111: ;
            4'b1110: begin is_one = 1'b1; one_idx = 2'd0; end
            4'b1101: begin is_one = 1'b1; one_idx = 2'd1; end
            4'b1011: begin is_one = 1'b1; one_idx = 2'd2; end
            4'b0111: begin is_one = 1'b1; one_idx = 2'd3; end
            default: is_multi = 1'b1;
        endcase
    end

    assign cnt_inc = cnt + 4'd1;

    // Next-state logic: count stable cycles for one digit, capture once, then
    // hold until the anode goes away. A multi-anode pattern is never "one",
    // so it falls back to idle from every state.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        digit_next = digit;
        held_next  = held;
        cap        = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_one) begin
                    digit_next = one_idx;
                    held_next  = char_r;
                    if (SETTLE_C == 4'd1) begin
                        cap        = 1'b1;
                        cnt_next   = 4'd0;
                        state_next = S_HOLD;
                    end else begin
                        cnt_next   = 4'd1;
                        state_next = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (is_one && one_idx == digit && char_r == held) begin
                    if (cnt_inc == SETTLE_C) begin
                        cap        = 1'b1;
                        cnt_next   = 4'd0;
                        state_next = S_HOLD;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end else begin
                    cnt_next   = 4'd0;
                    state_next = S_IDLE;
                end
            end
            S_HOLD: begin
                if (!(is_one && one_idx == digit)) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                cnt_next   = 4'd0;
                state_next = S_IDLE;
            end
        endcase
    end

    // Scan FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            digit <= 2'd0;
            held  <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            digit <= digit_next;
            held  <= held_next;
        end
    end

    assign commit   = (seen == 4'hF);
    assign seen_set = cap ? (4'b0001 << one_idx) : 4'b0000;

    // Shadow capture and seen tracking; a commit clears seen but a capture on
    // the same edge already counts toward the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            seen <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= 4'h0;
            end
        end else begin
            seen <= (commit ? 4'h0 : seen) | seen_set;
            if (cap) begin
                shadow[one_idx] <= char_r;
            end
        end
    end

    // Frame hand-off: commit loads all digits at once unless an unacked frame
    // is still pending, in which case the new one is dropped and flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            dig0        <= 4'h0;
            dig1        <= 4'h0;
            dig2        <= 4'h0;
            dig3        <= 4'h0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
            multi_err   <= 1'b0;
        end else begin
            if (is_multi) begin
                multi_err <= 1'b1;
            end
            if (commit) begin
                if (!frame_valid || frame_ack) begin
                    dig0        <= shadow[0];
                    dig1        <= shadow[1];
                    dig2        <= shadow[2];
                    dig3        <= shadow[3];
                    frame_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (frame_ack) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_decoder.sv
// Directed self-checking bench for disp_scan_decoder with SETTLE = 2.
module tb_disp_scan_decoder;

    logic       clk;
    logic       reset;
    logic       an0, an1, an2, an3;
    logic [3:0] char;
    logic       frame_ack;
    logic [3:0] dig0, dig1, dig2, dig3;
    logic       frame_valid;
    logic       overrun;
    logic       multi_err;

    int testCount;
    int failCount;

    disp_scan_decoder #(.SETTLE(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .an0        (an0),
        .an1        (an1),
        .an2        (an2),
        .an3        (an3),
        .char       (char),
        .frame_ack  (frame_ack),
        .dig0       (dig0),
        .dig1       (dig1),
        .dig2       (dig2),
        .dig3       (dig3),
        .frame_valid(frame_valid),
        .overrun    (overrun),
        .multi_err  (multi_err)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive the anode pattern {an3,an2,an1,an0} and char for a number of cycles.
    task automatic applyStimulus(input logic [3:0] pattern, input logic [3:0] value, input int cycles);
        {an3, an2, an1, an0} = pattern;
        char = value;
        tick(cycles);
    endtask

    // Light one digit for 4 cycles followed by a 2-cycle blank.
    task automatic scanDigit(input logic [1:0] k, input logic [3:0] value);
        logic [3:0] pattern;
        pattern = 4'hF;
        pattern[k] = 1'b0;
        applyStimulus(pattern, value, 4);
        applyStimulus(4'hF, 4'h0, 2);
    endtask

    // Full frame scan of digits 0..3.
    task automatic scanFrame(input logic [15:0] values);
        scanDigit(2'd0, values[3:0]);
        scanDigit(2'd1, values[7:4]);
        scanDigit(2'd2, values[11:8]);
        scanDigit(2'd3, values[15:12]);
    endtask

    // One-cycle acknowledge pulse.
    task automatic pulseAck();
        frame_ack = 1'b1;
        tick(1);
        frame_ack = 1'b0;
    endtask

    // One-cycle synchronous reset pulse with all anodes dark.
    task automatic pulseReset();
        {an3, an2, an1, an0} = 4'hF;
        char = 4'h0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        reset     = 1'b1;
        frame_ack = 1'b0;
        {an3, an2, an1, an0} = 4'hF;
        char = 4'h0;
        tick(2);
        reset = 1'b0;
        tick(1);

        checkOutput("reset_digits", {dig3, dig2, dig1, dig0}, 16'h0000);
        checkOutput("reset_valid", {15'd0, frame_valid}, 16'd0);
        checkOutput("reset_overrun", {15'd0, overrun}, 16'd0);
        checkOutput("reset_multi", {15'd0, multi_err}, 16'd0);

        // Normal frame 0,1,2,3 with latency check on the last digit.
        scanDigit(2'd0, 4'h0);
        scanDigit(2'd1, 4'h1);
        scanDigit(2'd2, 4'h2);
        applyStimulus(4'b0111, 4'h3, 3);
        checkOutput("latency_before", {15'd0, frame_valid}, 16'd0);
        applyStimulus(4'b0111, 4'h3, 1);
        checkOutput("latency_at", {15'd0, frame_valid}, 16'd1);
        applyStimulus(4'hF, 4'h0, 2);
        checkOutput("normal_digits", {dig3, dig2, dig1, dig0}, 16'h3210);
        checkOutput("normal_valid", {15'd0, frame_valid}, 16'd1);
        checkOutput("normal_overrun", {15'd0, overrun}, 16'd0);
        checkOutput("normal_multi", {15'd0, multi_err}, 16'd0);
        pulseAck();
        checkOutput("ack_clears", {15'd0, frame_valid}, 16'd0);
        pulseAck();
        checkOutput("ack_idle_ignored", {15'd0, frame_valid}, 16'd0);

        // Glitch on an1 for a single cycle must not count as digit 1.
        applyStimulus(4'b1101, 4'h9, 1);
        applyStimulus(4'hF, 4'h0, 3);
        scanDigit(2'd0, 4'hA);
        scanDigit(2'd2, 4'hB);
        scanDigit(2'd3, 4'hC);
        checkOutput("glitch_no_frame", {15'd0, frame_valid}, 16'd0);
        scanDigit(2'd1, 4'hD);
        checkOutput("glitch_then_valid", {15'd0, frame_valid}, 16'd1);
        checkOutput("glitch_digits", {dig3, dig2, dig1, dig0}, 16'hCBDA);
        pulseAck();

        // Two frames without acknowledge: first frame kept, overrun raised.
        scanFrame(16'h8765);
        checkOutput("ovr_first_valid", {15'd0, frame_valid}, 16'd1);
        checkOutput("ovr_first_flag", {15'd0, overrun}, 16'd0);
        scanFrame(16'hCBA9);
        checkOutput("ovr_digits", {dig3, dig2, dig1, dig0}, 16'h8765);
        checkOutput("ovr_flag", {15'd0, overrun}, 16'd1);
        checkOutput("ovr_valid", {15'd0, frame_valid}, 16'd1);
        pulseAck();
        checkOutput("ovr_ack_clears", {15'd0, frame_valid}, 16'd0);
        checkOutput("ovr_sticky", {15'd0, overrun}, 16'd1);
        pulseReset();
        checkOutput("ovr_reset_clears", {15'd0, overrun}, 16'd0);

        // Ack landing on the exact commit edge of the second frame.
        scanFrame(16'h4321);
        checkOutput("coll_first_valid", {15'd0, frame_valid}, 16'd1);
        scanDigit(2'd0, 4'hE);
        scanDigit(2'd1, 4'hD);
        scanDigit(2'd2, 4'hC);
        applyStimulus(4'b0111, 4'hB, 3);
        frame_ack = 1'b1;
        applyStimulus(4'b0111, 4'hB, 1);
        frame_ack = 1'b0;
        applyStimulus(4'hF, 4'h0, 2);
        checkOutput("coll_digits", {dig3, dig2, dig1, dig0}, 16'hBCDE);
        checkOutput("coll_valid", {15'd0, frame_valid}, 16'd1);
        checkOutput("coll_overrun", {15'd0, overrun}, 16'd0);
        pulseAck();

        // an0 and an2 low together: flagged, nothing captured.
        applyStimulus(4'b1010, 4'h7, 3);
        applyStimulus(4'hF, 4'h0, 2);
        checkOutput("multi_flag", {15'd0, multi_err}, 16'd1);
        scanDigit(2'd1, 4'h1);
        scanDigit(2'd2, 4'h4);
        scanDigit(2'd3, 4'h1);
        checkOutput("multi_no_capture", {15'd0, frame_valid}, 16'd0);
        scanDigit(2'd0, 4'h3);
        checkOutput("multi_clean_valid", {15'd0, frame_valid}, 16'd1);
        checkOutput("multi_clean_digits", {dig3, dig2, dig1, dig0}, 16'h1413);
        checkOutput("multi_sticky", {15'd0, multi_err}, 16'd1);

        // Reset in the middle of a frame loses the partial frame.
        pulseReset();
        scanDigit(2'd0, 4'h5);
        scanDigit(2'd1, 4'h6);
        pulseReset();
        scanDigit(2'd2, 4'h7);
        scanDigit(2'd3, 4'h8);
        checkOutput("rst_mid_valid", {15'd0, frame_valid}, 16'd0);
        checkOutput("rst_mid_digits", {dig3, dig2, dig1, dig0}, 16'h0000);
        checkOutput("rst_mid_overrun", {15'd0, overrun}, 16'd0);
        checkOutput("rst_mid_multi", {15'd0, multi_err}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/disp_scan_decoder.md
DISP_SCAN_DECODER -- requirements
Module: disp_scan_decoder

Interface
REQ-001 Parameter SETTLE, default 2, meaning the number of consecutive clk cycles an anode pattern must be stable before char is captured (legal range 1..15).
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 an0, an1, an2, an3  input  1 each  multiplexed digit anodes, active-low.
REQ-005 char  input  4  value presented for the currently lit digit.
REQ-006 dig0, dig1, dig2, dig3  output  4 each  last complete frame, one value per digit.
REQ-007 frame_valid  output  1  a complete frame is held on dig0..dig3.
REQ-008 frame_ack  input  1  consumer has taken the frame.
REQ-009 overrun  output  1  sticky flag: a frame completed while frame_valid was pending.
REQ-010 multi_err  output  1  sticky flag: two or more anodes were low in the same cycle.

Function
REQ-011 The block SHALL register an0..an3 and char once before any decision; all latencies are counted from the input edge.
REQ-012 The anode pattern SHALL be classified each cycle as NONE (all high), ONE(k) (exactly anode k low), or MULTI (two or more low).
REQ-013 The FSM SHALL have states IDLE, SETTLE, HOLD.
- IDLE: pattern ONE(k) -> SETTLE, counter=1, k latched; otherwise stay.
- SETTLE: same ONE(k) and same char -> counter++; counter reaching SETTLE -> capture char into shadow[k], set seen[k], -> HOLD.
- SETTLE: pattern or char changes -> IDLE, nothing captured.
- HOLD: stay while ONE(k) persists; any other pattern -> IDLE.
REQ-014 Only one capture SHALL occur per continuous lit interval of a digit, regardless of its length.
REQ-015 A MULTI pattern SHALL force IDLE, set multi_err, and capture nothing.
REQ-016 When seen[3:0] becomes 4'b1111, the block SHALL perform a frame commit on the following edge and clear seen.
REQ-017 A frame commit SHALL copy shadow[0..3] to dig0..dig3 atomically and set frame_valid.
REQ-018 Frame commit while frame_valid is already 1 and frame_ack is 0:
- dig0..dig3 keep the old frame.
- overrun is set.
- the new frame is discarded.
REQ-019 frame_ack high while frame_valid is high SHALL clear frame_valid on the next edge. frame_ack while frame_valid is low SHALL be ignored.
REQ-020 Simultaneous commit and frame_ack SHALL clear the old frame, load the new frame, and leave frame_valid at 1 with no overrun.
REQ-021 overrun and multi_err SHALL clear only on reset.
REQ-022 A recapture of a digit before frame completion SHALL overwrite shadow[k]; the last value wins.
REQ-023 Latency from the input edge on which char becomes stable (digit lit) to frame_valid rising, for the last digit of a frame, SHALL be 1 + SETTLE + 1 cycles.

Reset
REQ-024 While reset is high at an edge, the block SHALL set: FSM=IDLE, counter=0, seen=0, shadow=0, dig0..dig3=0, frame_valid=0, overrun=0, multi_err=0.
REQ-025 Reset SHALL take priority over all other events, including reset asserted in mid-SETTLE or mid-HOLD; a partial frame SHALL be lost.
REQ-026 After reset deasserts, the first capture SHALL require a fresh, full SETTLE interval.

Verification
REQ-027 Normal frame: scan digits 0..3 with char 0,1,2,3, each lit 4 cycles with a 2-cycle blank between digits, SETTLE=2 -> frame_valid=1; dig0..3=0,1,2,3; overrun=0; multi_err=0.
REQ-028 Glitch reject: an1 low for 1 cycle only (below SETTLE) -> no capture, seen[1] stays 0, no frame.
REQ-029 Overrun: complete two frames (5,6,7,8 then 9,A,B,C) with frame_ack held 0 -> dig0..3=5,6,7,8 and overrun=1; then frame_ack -> frame_valid=0 on the next cycle.
REQ-030 Multi-anode: an0 and an2 low together for 3 cycles -> multi_err=1, no capture; a later clean frame still commits.
REQ-031 Ack collision: frame_ack asserted on the exact commit edge of the second frame -> dig0..3 show the second frame, frame_valid=1, overrun=0.
REQ-032 Reset mid-frame: capture digits 0 and 1, pulse reset for 1 cycle, then scan digits 2 and 3 only -> no frame_valid and all outputs 0.
